// File: rtl/serializer_pkg.sv
// rtl/serializer_pkg.sv - shared types and helpers for the word serializer
//
// Purpose : FSM state encoding and bit-counter width helper used by
//           word_serializer.
// Ports   : none (package).
package serializer_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } ser_state_t;

  // Bit counter width for a WIDTH-bit word (counts 0..WIDTH-1).
  function automatic int cnt_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/word_serializer.sv
// rtl/word_serializer.sv - parallel-to-serial feed stage with one-word holding buffer
//
// Purpose : Accepts WIDTH-bit words over a valid/ready handshake and shifts
//           them out one bit per clock. A one-word holding buffer lets
//           back-to-back words stream with no gap cycles. IDLE_BIT fills the
//           line when nothing is in flight.
// Ports   : clk         - clock, rising edge
//           R           - synchronous active-high reset
//           load_data   - word to serialize
//           load_valid  - load_data is valid
//           load_ready  - block can accept a word this cycle
//           ser_out     - serial bit (registered)
//           ser_valid   - ser_out carries a data bit (registered)
//           frame_start - first bit of a word (registered)
//           busy        - shifter or holding buffer occupied (registered)
module word_serializer
  import serializer_pkg::*;
#(
  parameter int   WIDTH     = 8,
  parameter bit   MSB_FIRST = 1'b1,
  parameter logic IDLE_BIT  = 1'b0
) (
  input  logic             clk,
  input  logic             R,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             frame_start,
  output logic             busy
);

  localparam int            CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  ser_state_t       state;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] hold_word;
  logic             hold_full;
  logic             accept;

  // The bit that goes on the line first for a freshly loaded word.
  function automatic logic first_bit(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  // Advance the shifter by one bit: left for MSB-first, right for LSB-first.
  function automatic logic [WIDTH-1:0] shift_word(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
  endfunction

  assign load_ready = !hold_full && !R;
  assign accept     = load_valid && load_ready;

  // Outputs are computed from the values being loaded at this edge so the
  // first bit of an accepted word appears in the very next cycle.
  always_ff @(posedge clk) begin
    if (R) begin
      state       <= IDLE;
      count       <= '0;
      hold_full   <= 1'b0;
      ser_out     <= IDLE_BIT;
      ser_valid   <= 1'b0;
      frame_start <= 1'b0;
      busy        <= 1'b0;
    end else if (state == IDLE) begin
      if (accept) begin
        state       <= SHIFT;
        count       <= '0;
        shreg       <= load_data;
        ser_out     <= first_bit(load_data);
        ser_valid   <= 1'b1;
        frame_start <= 1'b1;
        busy        <= 1'b1;
      end
    end else begin
      if (count == LAST) begin
        if (hold_full) begin
          // Held word takes priority; load_ready is low so no accept can race it.
          shreg       <= hold_word;
          ser_out     <= first_bit(hold_word);
          hold_full   <= 1'b0;
          count       <= '0;
          frame_start <= 1'b1;
          busy        <= 1'b1;
        end else if (accept) begin
          // Last-bit bypass: incoming word goes straight to the shifter.
          shreg       <= load_data;
          ser_out     <= first_bit(load_data);
          count       <= '0;
          frame_start <= 1'b1;
          busy        <= 1'b1;
        end else begin
          state       <= IDLE;
          ser_out     <= IDLE_BIT;
          ser_valid   <= 1'b0;
          frame_start <= 1'b0;
          busy        <= 1'b0;
        end
      end else begin
        shreg       <= shift_word(shreg);
        ser_out     <= first_bit(shift_word(shreg));
        count       <= count + CW'(1);
        frame_start <= 1'b0;
        busy        <= 1'b1;
        if (accept) begin
          hold_word <= load_data;
          hold_full <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_word_serializer.sv
// tb/tb_word_serializer.sv - self-checking bench for word_serializer
module tb_word_serializer;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] load_data;
  logic         load_valid;

  logic a_ready, a_ser, a_sv, a_fs, a_busy;
  logic b_ready, b_ser, b_sv, b_fs, b_busy;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: words resident in the block (front = shifting word)
  // and the index of the bit currently on the line.
  logic [W-1:0] mq[$];
  int           mpos;

  always #5 clk = ~clk;

  word_serializer #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) u_msb (
    .clk(clk), .R(rst), .load_data(load_data), .load_valid(load_valid),
    .load_ready(a_ready), .ser_out(a_ser), .ser_valid(a_sv),
    .frame_start(a_fs), .busy(a_busy)
  );

  word_serializer #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_BIT(1'b1)) u_lsb (
    .clk(clk), .R(rst), .load_data(load_data), .load_valid(load_valid),
    .load_ready(b_ready), .ser_out(b_ser), .ser_valid(b_sv),
    .frame_start(b_fs), .busy(b_busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic model_bit(input bit msb, input logic idle);
    logic [W-1:0] w;
    if (mq.size() == 0) return idle;
    w = mq[0];
    return msb ? w[W-1-mpos] : w[mpos];
  endfunction

  // One clock: apply inputs at the falling edge, compare every output of
  // both builds against the model, then advance the model past the next
  // rising edge.
  task automatic step(input logic r, input logic v, input logic [W-1:0] d, output bit acc);
    logic e_ready, e_busy, e_fs;
    @(negedge clk);
    rst = r; load_valid = v; load_data = d;
    #1;
    e_ready = (mq.size() < 2) && !r;
    e_busy  = (mq.size() > 0);
    e_fs    = e_busy && (mpos == 0);
    check("msb_ready", a_ready, e_ready);
    check("msb_ser",   a_ser,   model_bit(1'b1, 1'b0));
    check("msb_valid", a_sv,    e_busy);
    check("msb_fs",    a_fs,    e_fs);
    check("msb_busy",  a_busy,  e_busy);
    check("lsb_ready", b_ready, e_ready);
    check("lsb_ser",   b_ser,   model_bit(1'b0, 1'b1));
    check("lsb_valid", b_sv,    e_busy);
    check("lsb_fs",    b_fs,    e_fs);
    check("lsb_busy",  b_busy,  e_busy);
    acc = v && e_ready;
    if (r) begin
      mq.delete();
      mpos = 0;
    end else begin
      if (mq.size() > 0) begin
        mpos++;
        if (mpos == W) begin
          void'(mq.pop_front());
          mpos = 0;
        end
      end
      if (acc) mq.push_back(d);
    end
  endtask

  task automatic send(input logic [W-1:0] d);
    bit acc = 1'b0;
    for (int i = 0; i < 40 && !acc; i++) step(1'b0, 1'b1, d, acc);
    if (!acc) check("send_timeout", 0, 1);
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, acc);
  endtask

  task automatic drain();
    bit acc;
    for (int i = 0; i < 40 && mq.size() > 0; i++) step(1'b0, 1'b0, '0, acc);
    if (mq.size() > 0) check("drain_timeout", 0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    bit done;
    rst = 1'b1; load_valid = 1'b0; load_data = '0;
    repeat (3) @(posedge clk);
    mq.delete();
    mpos = 0;

    // Reset state, with a handshake offered during reset (must be ignored).
    step(1'b1, 1'b1, 8'h55, acc);
    step(1'b1, 1'b0, '0, acc);

    // Single words.
    send(8'hA5);
    idle(12);
    send(8'h01);
    idle(12);

    // Back-to-back stream with load_valid held.
    send(8'hFF);
    send(8'h00);
    send(8'h5A);
    drain();
    idle(3);

    // Last-bit bypass: offer only in the last-bit cycle with buffer empty.
    send(8'h3C);
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      step(1'b0, (mq.size() == 1 && mpos == W-1), 8'hC3, acc);
      if (acc) done = 1'b1;
    end
    if (!done) check("bypass_timeout", 0, 1);
    drain();
    idle(2);

    // Reset mid-word with a held word present.
    send(8'hA5);
    send(8'h77);
    for (int i = 0; i < 20 && mpos != 4; i++) step(1'b0, 1'b0, '0, acc);
    check("held_present", mq.size(), 2);
    step(1'b1, 1'b0, '0, acc);
    idle(12);

    // Idle fill.
    idle(20);

    // Random traffic with occasional resets.
    for (int i = 0; i < 800; i++) begin
      step(($urandom_range(0, 49) == 0), ($urandom_range(0, 1) == 1),
           W'($urandom), acc);
    end
    drain();
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/word_serializer.md
# word_serializer

Parallel-to-serial feed stage upstream of the Moore overlapping "101" detector: accepts WIDTH-bit words over a valid/ready handshake and drives them out one bit per clock on a single serial line, which connects directly to the detector's `in` port. A one-word holding buffer lets back-to-back words stream with no gap cycles. When no word is in flight, the line carries a fixed idle bit so the detector sees a defined stream.

## Interface
- `WIDTH`, default 8: word width in bits; legal range 2..32.
- `MSB_FIRST`, default 1: 1 sends bit WIDTH-1 first; 0 sends bit 0 first.
- `IDLE_BIT`, default 1'b0: value driven on `ser_out` when no word is in flight.

- `clk`  input  1: single clock, all logic on rising edge.
- `R`  input  1: reset, synchronous, active-high.
- `load_data`  input  WIDTH: word to serialize.
- `load_valid`  input  1: `load_data` is valid.
- `load_ready`  output  1: block can accept a word this cycle.
- `ser_out`  output  1: serial bit; drives the detector's `in`.
- `ser_valid`  output  1: `ser_out` carries a data bit (not idle fill).
- `frame_start`  output  1: high for the first bit of each word.
- `busy`  output  1: shifter or holding buffer occupied.

## Operation
- Handshake: a word is accepted at an edge where `load_valid && load_ready` is high. `load_data` may change freely when not accepted.
- `load_ready = !hold_full && !R`. This is combinational from registered state and `R`.
- FSM states: IDLE, SHIFT.
  - IDLE → SHIFT on accept. The word loads directly into the shifter, bypassing the holding buffer.
  - In SHIFT, the bit counter counts 0..WIDTH-1.
  - On the last bit (count == WIDTH-1):
    - If `hold_full`, move the held word into the shifter, clear `hold_full`, stay in SHIFT, and reset the count to 0.
    - Else if accept occurs this edge, load the incoming word into the shifter, stay in SHIFT, and reset the count.
    - Otherwise go to IDLE.
  - In SHIFT, not on the last bit: an accepted word goes to the holding buffer and sets `hold_full`.
- Outputs are registered:
  - `ser_out` = current shifter bit in SHIFT, `IDLE_BIT` in IDLE.
  - `ser_valid` = state==SHIFT.
  - `frame_start` = SHIFT && count==0.
  - `busy` = SHIFT || `hold_full`.
- Bit order is fixed by `MSB_FIRST` at elaboration. Shift direction is left for MSB-first and right for LSB-first.
- Counter width is $clog2(WIDTH). The counter never exceeds WIDTH-1; it wraps to 0 only on a reload.
- Reset: state=IDLE, count=0, `hold_full`=0, `ser_out`=`IDLE_BIT`, `ser_valid`=0, `frame_start`=0, `busy`=0, `load_ready`=0 while `R` is high.
- Reset mid-word: the word in flight and the held word are discarded. `ser_out` returns to `IDLE_BIT` after the reset edge.
- A handshake in the same cycle as `R` is ignored; `load_ready` is already low.

## Timing
- Latency: the word is accepted at edge E0 from IDLE. Its first bit is on `ser_out` with `ser_valid=frame_start=1` in the cycle after E0. Its last bit follows WIDTH-1 cycles later.
- Throughput: one bit per clock. Continuous supply gives zero idle cycles between words, and `frame_start` pulses every WIDTH cycles.
- `load_ready` drops the cycle after a word enters the holding buffer. It rises the cycle after the held word moves to the shifter.
- Maximum two words are resident: one shifting, one held.

## Structure
- Shared package `serializer_pkg`:
  - typedef `ser_state_t` enum {IDLE, SHIFT}.
  - Localparam helper for the counter width.
- Single module; no sub-module. The holding buffer is a plain register plus the `hold_full` flag.

## Test plan
- Reset, then one word: WIDTH=8, MSB_FIRST=1, send 8'hA5 → `ser_out` 1,0,1,0,0,1,0,1 over 8 cycles. `frame_start` is high on the first bit only, then the line returns to idle 0. A downstream detector pulses twice (overlapping "101" at bits 3 and 8).
- LSB_FIRST build (MSB_FIRST=0), 8'h01 → `ser_out` 1 then seven 0s.
- Back-to-back: hold `load_valid` high with 8'hFF, 8'h00, 8'h5A → 24 consecutive `ser_valid` cycles with `frame_start` at cycles 0, 8, 16. `load_ready` is low while the buffer is full.
- Last-bit bypass: offer a word only in the last-bit cycle with the buffer empty → accepted, no gap, `frame_start` on the next cycle.
- Reset mid-word: assert `R` at bit 4 of 8'hA5 with a held word present → after the reset edge `ser_valid=0`, `busy=0`, and neither word is emitted. `load_ready` is 0 during `R` and 1 after.
- Idle fill: with IDLE_BIT=1 and no traffic for 20 cycles → `ser_out`=1 and `ser_valid`=0 throughout.
